// File: rtl/hough_line_renderer_if.sv
// Trig-ROM lookup and frame-buffer write bus of the Hough line renderer.
// The renderer is the master; the ROM/frame-buffer side is the slave.
interface hough_line_renderer_if #(
    parameter int THETA_W = 8,
    parameter int ADDR_W  = 19
);
    logic        [THETA_W-1:0] lut_theta_idx;
    logic signed [15:0]        cos_q;
    logic signed [15:0]        sin_q;
    logic        [ADDR_W-1:0]  wr_addr;
    logic        [1:0]         wr_data;
    logic                      wr_en;

    modport master (
        output lut_theta_idx, wr_addr, wr_data, wr_en,
        input  cos_q, sin_q
    );

    modport slave (
        input  lut_theta_idx, wr_addr, wr_data, wr_en,
        output cos_q, sin_q
    );
endinterface

// File: rtl/hough_line_renderer.sv
// Renders a table of Hough (theta, rho) lines into a 2-bit frame buffer,
// one pixel write per scan of the line table, in ascending address order.
module hough_line_renderer #(
    parameter int IMG_WIDTH   = 640,
    parameter int IMG_HEIGHT  = 480,
    parameter int THETA_STEPS = 180,
    parameter int RHO_BINS    = 1024,
    parameter int MAX_LINES   = 16,
    parameter int TOL         = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] num_lines,
    input  logic [15:0] line_theta [0:MAX_LINES-1],
    input  logic [15:0] line_rho   [0:MAX_LINES-1],
    hough_line_renderer_if.master bus,
    output logic        busy,
    output logic        done
);
    localparam int THETA_W = (THETA_STEPS > 1) ? $clog2(THETA_STEPS) : 1;
    localparam int ADDR_W  = $clog2(IMG_WIDTH * IMG_HEIGHT);
    localparam int X_W     = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int Y_W     = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int K_W     = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
    localparam int LINE_W  = $clog2(MAX_LINES + 1);

    localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(IMG_WIDTH * IMG_HEIGHT - 1);
    localparam logic [X_W-1:0]    X_LAST   = X_W'(IMG_WIDTH - 1);
    localparam logic signed [31:0] RHO_OFF = 32'(RHO_BINS / 2);
    localparam logic signed [31:0] TOL_S   = 32'(TOL);

    typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_CAP, SCAN, WRITE, DONE} state_t;

    state_t             r_state;
    logic [LINE_W-1:0]  r_n;
    logic [LINE_W-1:0]  r_k;
    logic [ADDR_W-1:0]  r_pix;
    logic [X_W-1:0]     r_x;
    logic [Y_W-1:0]     r_y;
    logic               r_hit;
    logic [THETA_W-1:0] r_lut_theta_idx;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [1:0]         r_wr_data;
    logic               r_wr_en;
    logic               r_busy;
    logic               r_done;

    logic        [THETA_W-1:0] r_theta [MAX_LINES];
    logic        [15:0]        r_rho   [MAX_LINES];
    logic                      r_valid [MAX_LINES];
    logic signed [15:0]        r_cos   [MAX_LINES];
    logic signed [15:0]        r_sin   [MAX_LINES];

    logic [LINE_W-1:0]  w_n_start;
    logic [K_W-1:0]     w_k_idx;
    logic [K_W-1:0]     w_k_next_idx;
    logic               w_last_line;
    logic signed [31:0] w_x_s, w_y_s, w_cos_s, w_sin_s, w_rho_s;
    logic signed [31:0] w_dot, w_rho_pix, w_diff;
    logic               w_line_hit;
    logic               w_pix_hit;

    assign w_n_start    = (num_lines > 16'(MAX_LINES)) ? LINE_W'(MAX_LINES) : LINE_W'(num_lines);
    assign w_k_idx      = K_W'(r_k);
    assign w_k_next_idx = K_W'(r_k + 1'b1);
    assign w_last_line  = (r_k == r_n - 1'b1);

    // rho of the current pixel against line k, 32-bit signed with flooring shift
    assign w_x_s     = 32'(r_x);
    assign w_y_s     = 32'(r_y);
    assign w_cos_s   = 32'(r_cos[w_k_idx]);
    assign w_sin_s   = 32'(r_sin[w_k_idx]);
    assign w_rho_s   = 32'(r_rho[w_k_idx]);
    assign w_dot     = w_x_s * w_cos_s + w_y_s * w_sin_s;
    assign w_rho_pix = (w_dot >>> 15) + RHO_OFF;
    assign w_diff    = w_rho_pix - w_rho_s;

    assign w_line_hit = r_valid[w_k_idx] && (w_diff >= -TOL_S) && (w_diff <= TOL_S);
    // The accumulator restarts at line 0 of every pixel; an empty table never hits.
    assign w_pix_hit  = (r_n != '0) && (w_line_hit || (r_hit && (r_k != '0)));

    // NOTE: state and outputs use non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_n             <= '0;
            r_k             <= '0;
            r_pix           <= '0;
            r_x             <= '0;
            r_y             <= '0;
            r_hit           <= 1'b0;
            r_lut_theta_idx <= '0;
            r_wr_addr       <= '0;
            r_wr_data       <= 2'b00;
            r_wr_en         <= 1'b0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_wr_en <= 1'b0;
                    r_done  <= 1'b0;
                    if (start) begin
                        r_n    <= w_n_start;
                        r_k    <= '0;
                        r_pix  <= '0;
                        r_x    <= '0;
                        r_y    <= '0;
                        r_hit  <= 1'b0;
                        r_busy <= 1'b1;
                        if (w_n_start == '0) begin
                            r_state <= SCAN;
                        end else begin
                            r_state         <= LOAD_REQ;
                            r_lut_theta_idx <= line_theta[0][THETA_W-1:0];
                        end
                    end
                end
                LOAD_REQ: r_state <= LOAD_CAP;
                LOAD_CAP: begin
                    if (w_last_line) begin
                        r_k     <= '0;
                        r_state <= SCAN;
                    end else begin
                        r_k             <= r_k + 1'b1;
                        r_lut_theta_idx <= r_theta[w_k_next_idx];
                        r_state         <= LOAD_REQ;
                    end
                end
                SCAN: begin
                    r_hit <= w_pix_hit;
                    if (r_n == '0 || w_last_line) begin
                        r_k       <= '0;
                        r_state   <= WRITE;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_pix;
                        r_wr_data <= w_pix_hit ? 2'b11 : 2'b00;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                WRITE: begin
                    if (r_pix == PIX_LAST) begin
                        r_state <= DONE;
                        r_wr_en <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_pix <= r_pix + 1'b1;
                        if (r_x == X_LAST) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                        // With no lines there is nothing to scan: stream one pixel per cycle.
                        if (r_n == '0) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_pix + 1'b1;
                            r_wr_data <= 2'b00;
                        end else begin
                            r_wr_en <= 1'b0;
                            r_state <= SCAN;
                        end
                    end
                end
                DONE: begin
                    if (!start) begin
                        r_state <= IDLE;
                        r_done  <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // NOTE: line storage carries no reset; each entry is written at start or load before it is read.
    always_ff @(posedge clk) begin
        if (r_state == IDLE && start) begin
            for (int i = 0; i < MAX_LINES; i++) begin
                r_theta[i] <= line_theta[i][THETA_W-1:0];
                r_rho[i]   <= line_rho[i];
                r_valid[i] <= (line_theta[i] < 16'(THETA_STEPS));
            end
        end
        if (r_state == LOAD_CAP) begin
            r_cos[w_k_idx] <= bus.cos_q;
            r_sin[w_k_idx] <= bus.sin_q;
        end
    end

    assign bus.lut_theta_idx = r_lut_theta_idx;
    assign bus.wr_addr       = r_wr_addr;
    assign bus.wr_data       = r_wr_data;
    assign bus.wr_en         = r_wr_en;
    assign busy              = r_busy;
    assign done              = r_done;
endmodule

// File: tb/tb_hough_line_renderer.sv
// Scoreboard bench for hough_line_renderer on an 8x4 frame: a floor-division
// reference model fills the expected-write queue, a monitor drains it.
module tb_hough_line_renderer;
    localparam int W         = 8;
    localparam int H         = 4;
    localparam int NPIX      = W * H;
    localparam int THETA_ST  = 180;
    localparam int RHO_BINS  = 1024;
    localparam int MAX_LINES = 16;
    localparam int TOL       = 0;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] num_lines;
    logic [15:0] line_theta [0:MAX_LINES-1];
    logic [15:0] line_rho   [0:MAX_LINES-1];
    logic        busy;
    logic        done;

    hough_line_renderer_if #(.THETA_W(8), .ADDR_W(5)) ifc ();

    hough_line_renderer #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .THETA_STEPS(THETA_ST),
        .RHO_BINS   (RHO_BINS),
        .MAX_LINES  (MAX_LINES),
        .TOL        (TOL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .num_lines (num_lines),
        .line_theta(line_theta),
        .line_rho  (line_rho),
        .bus       (ifc),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Synchronous trig ROM: data appears the cycle after its address.
    logic signed [15:0] rom_cos [256];
    logic signed [15:0] rom_sin [256];
    always @(posedge clk) begin
        ifc.cos_q <= rom_cos[ifc.lut_theta_idx];
        ifc.sin_q <= rom_sin[ifc.lut_theta_idx];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] snap_theta [16];
    logic [15:0] snap_rho   [16];

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int floor_div(input int a, input int b);
        int q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q--;
        return q;
    endfunction

    // Monitor: every write strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (ifc.wr_en) begin
            if (sb.size() == 0) begin
                check("unexpected_write", ifc.wr_en, 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", ifc.wr_addr, e.addr);
                check("wr_data", ifc.wr_data, e.data);
                check("wr_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic rand_tables(input bit allow_bad);
        for (int k = 0; k < MAX_LINES; k++) begin
            if (allow_bad && $urandom_range(0, 4) == 0) line_theta[k] = 16'($urandom_range(180, 255));
            else line_theta[k] = 16'($urandom_range(0, 179));
            line_rho[k] = 16'($urandom_range(504, 520));
        end
    endtask

    // Snapshot the table, predict every write, then raise start.
    task automatic launch(output int s0, output int n, output int first, output int per);
        @(negedge clk);
        n = (int'(num_lines) > MAX_LINES) ? MAX_LINES : int'(num_lines);
        for (int k = 0; k < MAX_LINES; k++) begin
            snap_theta[k] = line_theta[k];
            snap_rho[k]   = line_rho[k];
        end
        first = (n == 0) ? 1 : 3 * n;
        per   = (n == 0) ? 1 : n + 1;
        s0    = cyc + 1;
        for (int p = 0; p < NPIX; p++) begin
            int x, y, dot, rho;
            bit hit;
            x   = p % W;
            y   = p / W;
            hit = 1'b0;
            for (int k = 0; k < n; k++) begin
                if (snap_theta[k] < THETA_ST) begin
                    dot = x * int'(rom_cos[snap_theta[k][7:0]]) + y * int'(rom_sin[snap_theta[k][7:0]]);
                    rho = floor_div(dot, 32768) + RHO_BINS / 2;
                    if (rho - int'(snap_rho[k]) <= TOL && int'(snap_rho[k]) - rho <= TOL) hit = 1'b1;
                end
            end
            sb.push_back('{addr: p, data: hit ? 3 : 0, cyc: s0 + first + p * per});
        end
        start = 1'b1;
    endtask

    task automatic render(input bit disturb, input bit hold);
        int s0, n, first, per;
        logic [7:0] exp_idx;
        launch(s0, n, first, per);
        @(negedge clk);
        check("busy_on", busy, 1);
        check("done_low", done, 0);
        if (!hold) start = 1'b0;
        for (int j = 0; j < n; j++) begin
            while (cyc < s0 + 2 * j) @(negedge clk);
            exp_idx = snap_theta[j][7:0];
            check("lut_theta_idx", ifc.lut_theta_idx, exp_idx);
        end
        if (disturb) begin
            for (int t = 0; t < 4; t++) begin
                @(negedge clk);
                start         = ~start;
                line_theta[t] = 16'($urandom);
                line_rho[t]   = 16'($urandom);
                num_lines     = 16'($urandom);
            end
        end
        while (cyc < s0 + first + (NPIX - 1) * per + 1) @(negedge clk);
        check("done_set", done, 1);
        check("busy_off", busy, 0);
        check("sb_drained", sb.size(), 0);
        if (hold) begin
            for (int t = 0; t < 10; t++) begin
                @(negedge clk);
                check("done_hold", done, 1);
                check("busy_hold", busy, 0);
            end
            start = 1'b0;
        end
        @(negedge clk);
        check("done_clear", done, 0);
        check("busy_idle", busy, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, n, first, per;
        rst_n     = 1'b1;
        start     = 1'b0;
        num_lines = '0;
        for (int k = 0; k < MAX_LINES; k++) begin
            line_theta[k] = '0;
            line_rho[k]   = '0;
        end
        for (int i = 0; i < 256; i++) begin
            rom_cos[i] = 16'($urandom);
            rom_sin[i] = 16'($urandom);
        end
        rom_cos[0]   = 16'sh4000;
        rom_sin[0]   = 16'sh0000;
        rom_cos[200] = 16'sh0000;
        rom_sin[200] = 16'sh0000;

        #2 rst_n = 1'b0;
        #1;
        check("rst_wr_en", ifc.wr_en, 0);
        check("rst_wr_addr", ifc.wr_addr, 0);
        check("rst_wr_data", ifc.wr_data, 0);
        check("rst_lut_idx", ifc.lut_theta_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Empty table: 32 background writes on consecutive cycles.
        num_lines = 16'd0;
        render(1'b0, 1'b0);

        // Vertical line: x*0.5 floors to bin 513 only for x=2,3.
        line_theta[0] = 16'd0;
        line_rho[0]   = 16'd513;
        num_lines     = 16'd1;
        render(1'b0, 1'b0);

        // Oversized count is clamped to the table depth.
        rand_tables(1'b0);
        num_lines = 16'd20;
        render(1'b0, 1'b0);

        // Out-of-range theta: ROM entry would hit every pixel if it were used.
        line_theta[0] = 16'd200;
        line_rho[0]   = 16'd512;
        num_lines     = 16'd1;
        render(1'b0, 1'b0);

        for (int t = 0; t < 5; t++) begin
            rand_tables(1'b1);
            num_lines = 16'($urandom_range(1, 6));
            render(1'b0, 1'b0);
        end

        // Abort at pixel 10, then a fresh render from address 0.
        rand_tables(1'b0);
        num_lines = 16'd2;
        launch(s0, n, first, per);
        @(negedge clk);
        start = 1'b0;
        while (cyc < s0 + first + 10 * per) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_wr_en", ifc.wr_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wr_addr", ifc.wr_addr, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        rand_tables(1'b1);
        num_lines = 16'd3;
        render(1'b0, 1'b0);

        // start toggled and table scrambled mid-render, then start held after completion.
        rand_tables(1'b0);
        num_lines = 16'd3;
        render(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hough_line_renderer.md
HOUGH_LINE_RENDERER -- requirements
Module: hough_line_renderer

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH, default 640, meaning frame width in pixels.
REQ-002 The block SHALL have parameter IMG_HEIGHT, default 480, meaning frame height in pixels.
REQ-003 The block SHALL have parameter THETA_STEPS, default 180, meaning the number of theta indices.
REQ-004 The block SHALL have parameter RHO_BINS, default 1024, meaning the number of rho bins, with rho offset RHO_BINS/2.
REQ-005 The block SHALL have parameter MAX_LINES, default 16, meaning the line table depth.
REQ-006 The block SHALL have parameter TOL, default 1, meaning the hit tolerance in rho bins.
REQ-007 The block SHALL have port clk, input, 1 bit, meaning the clock.
REQ-008 The block SHALL have port rst_n, input, 1 bit, meaning the reset, which is asynchronous and active-low.
REQ-009 The block SHALL have port start, input, 1 bit, meaning the render request (level).
REQ-010 The block SHALL have port num_lines, input, 16 bits, meaning the count of valid table entries.
REQ-011 The block SHALL have port line_theta[0:MAX_LINES-1], input, 16 bits each, meaning the theta index per line.
REQ-012 The block SHALL have port line_rho[0:MAX_LINES-1], input, 16 bits each, meaning the rho bin per line.
REQ-013 The block SHALL have port lut_theta_idx, output, $clog2(THETA_STEPS) bits, meaning the trig ROM address.
REQ-014 The block SHALL have port cos_q, input, 16 bits signed Q1.15, meaning the ROM cosine, valid 1 cycle after its address.
REQ-015 The block SHALL have port sin_q, input, 16 bits signed Q1.15, meaning the ROM sine, valid 1 cycle after its address.
REQ-016 The block SHALL have port wr_addr, output, $clog2(IMG_WIDTH*IMG_HEIGHT) bits, meaning the frame-buffer write address.
REQ-017 The block SHALL have port wr_data, output, 2 bits, meaning the pixel value: 2'b11 for a line pixel, 2'b00 for background.
REQ-018 The block SHALL have port wr_en, output, 1 bit, meaning the write strobe, asserted for one cycle per pixel.
REQ-019 The block SHALL have port busy, output, 1 bit, meaning high in any state except IDLE and DONE.
REQ-020 The block SHALL have port done, output, 1 bit, meaning the render is complete (level).

Function
REQ-021 The block SHALL use the states IDLE, LOAD_REQ, LOAD_CAP, SCAN, WRITE and DONE.
REQ-022 In IDLE with start=1, the block SHALL latch min(num_lines, MAX_LINES) as n, latch the line table, clear the pixel counter and line index k, and go to LOAD_REQ, or to SCAN when n=0.
REQ-023 In LOAD_REQ, the block SHALL drive lut_theta_idx=line_theta[k][THETA_W-1:0] and then go to LOAD_CAP.
REQ-024 In LOAD_CAP, the block SHALL store cos_q and sin_q into the per-line registers for k, then increment k, or go to SCAN after line n-1 with k cleared.
REQ-025 The load phase SHALL take exactly 2n cycles.
REQ-026 A line with line_theta >= THETA_STEPS SHALL be marked invalid at load and SHALL never hit.
REQ-027 For pixel p at (x=p%IMG_WIDTH, y=p/IMG_WIDTH), the block SHALL compute rho_pix = ((x*cos_k + y*sin_k) >>> 15) + RHO_BINS/2, using 32-bit signed arithmetic with an arithmetic shift that floors.
REQ-028 SCAN SHALL evaluate one line per cycle for k=0..n-1, and line k SHALL hit when valid and |rho_pix - line_rho[k]| <= TOL, compared as signed 32-bit.
REQ-029 The block SHALL OR-accumulate hits across lines, clearing the accumulator at the start of each pixel.
REQ-030 After the last line is evaluated, or immediately when n=0, the block SHALL go to WRITE.
REQ-031 In WRITE, wr_en SHALL be 1 for exactly one cycle, with wr_addr=p and wr_data=2'b11 if any line hit, else 2'b00.
REQ-032 The block SHALL take n+1 cycles per pixel for n>=1, and 1 cycle per pixel for n=0.
REQ-033 Pixels SHALL be written in ascending address order 0..IMG_WIDTH*IMG_HEIGHT-1, each exactly once.
REQ-034 After writing p=IMG_WIDTH*IMG_HEIGHT-1, the block SHALL go to DONE; the pixel counter SHALL NOT wrap.
REQ-035 In DONE, done SHALL be 1; the block SHALL return to IDLE on the first cycle with start=0, and done SHALL then be 0.
REQ-036 When start is held high in DONE, the block SHALL stay in DONE and SHALL NOT re-render.
REQ-037 start and line-table changes while busy SHALL be ignored, because the line table is latched at start.
REQ-038 wr_en SHALL be 0 in all states except WRITE.

Reset
REQ-039 On rst_n=0, the block SHALL immediately and asynchronously enter IDLE and drive wr_en=0, wr_addr=0, wr_data=0, lut_theta_idx=0, busy=0 and done=0.
REQ-040 A reset mid-render SHALL abort the render with no further writes, and the next start SHALL restart from address 0 with a fresh load.

Verification
REQ-041 The bench SHALL cover: IMG 8x4, num_lines=0, start -> 32 writes of 2'b00, addresses 0..31 on consecutive cycles, then done=1.
REQ-042 The bench SHALL cover: IMG 8x4, TOL=0, one line theta=0 with the bench ROM returning cos_q=0x4000 and sin_q=0, line_rho=513 -> 2'b11 exactly at x=2,3 in every row, 2'b00 elsewhere, with 2 cycles per pixel.
REQ-043 The bench SHALL cover: num_lines=20 -> exactly 16 LOAD_REQ ROM addresses and 17 cycles per pixel.
REQ-044 The bench SHALL cover: one line with line_theta=200 (THETA_STEPS=180) -> all pixels 2'b00.
REQ-045 The bench SHALL cover: rst_n pulsed low at pixel 10 -> wr_en=0 and busy=0 in the same cycle; the next start writes from address 0.
REQ-046 The bench SHALL cover: start toggled mid-render, then start held high after completion -> the render is unaffected, done stays 1 until start=0, then IDLE with no second render.
